// File: rtl/memory_access_stage_if.sv
// memory_access_stage_if
//   Data-memory bus between the MEM stage (master) and the data memory
//   (slave). Only one request is outstanding at a time. The master holds
//   every request field steady while mem_req is high, and the slave
//   completes the request by raising mem_ready for one cycle.
//   Signals:
//     mem_addr   master->slave  word-aligned byte address
//     mem_wdata  master->slave  lane-placed store data
//     mem_wstrb  master->slave  byte strobes (0 for loads)
//     mem_we     master->slave  write request
//     mem_req    master->slave  request valid
//     mem_ready  slave->master  request complete
//     mem_rdata  slave->master  read word, valid with mem_ready
interface memory_access_stage_if #(
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic [3:0]            mem_wstrb;
   logic                  mem_we;
   logic                  mem_req;
   logic                  mem_ready;
   logic [31:0]           mem_rdata;

   modport master (
      output mem_addr, mem_wdata, mem_wstrb, mem_we, mem_req,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_wstrb, mem_we, mem_req,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/memory_access_stage.sv
// memory_access_stage
//   MEM stage of the RV32IM pipeline. It takes the EX/MEM register and
//   issues at most one data-memory request at a time. It places store data
//   on the correct byte lanes and sign- or zero-extends load data. It also
//   owns the MEM/WB register and stalls the front of the pipeline while a
//   request is in flight.
//   Ports:
//     clk, reset_n            clock, asynchronous active-low reset
//     alu_result, data2       effective address / ALU result, store data
//     funct3, rd              access size/sign, destination register
//     memory_read_enable      load
//     memory_write_enable     store
//     regwrite_enable         writeback enable
//     mux3_select             WB select (0 = ALU, 1 = load data)
//     mem                     data-memory bus (master side)
//     wb_*                    MEM/WB pipeline register
//     stall                   freezes PC, IF/ID, ID/EX and EX/MEM
//     mem_fault               one-cycle pulse: misaligned, illegal or timeout
module memory_access_stage #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int ADDR_WIDTH     = 32
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [31:0]                alu_result,
   input  logic [31:0]                data2,
   input  logic [2:0]                 funct3,
   input  logic [4:0]                 rd,
   input  logic                       memory_read_enable,
   input  logic                       memory_write_enable,
   input  logic                       regwrite_enable,
   input  logic                       mux3_select,
   memory_access_stage_if.master      mem,
   output logic [31:0]                wb_alu_result,
   output logic [31:0]                wb_read_data,
   output logic [4:0]                 wb_rd,
   output logic                       wb_regwrite_enable,
   output logic                       wb_mux3_select,
   output logic                       stall,
   output logic                       mem_fault
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t      state, state_nxt;
   logic [7:0]  cnt;
   logic [1:0]  lat_off;
   logic [2:0]  lat_f3;
   logic        lat_load;

   logic        op, illegal, misaligned, legal_op;
   logic        done, timeout_now;
   logic [31:0] st_data, ld_data;
   logic [3:0]  st_strb;
   logic [31:0] ld_shift;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // ---------------- request decode ----------------
   assign op = memory_read_enable | memory_write_enable;

   always_comb begin
      illegal = memory_read_enable & memory_write_enable;
      if (memory_read_enable && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111))
         illegal = 1'b1;
      if (memory_write_enable && funct3 != 3'b000 && funct3 != 3'b001 && funct3 != 3'b010)
         illegal = 1'b1;
   end

   // funct3[1:0] carries the size for both signed and unsigned loads
   assign misaligned = (funct3[1:0] == 2'b01 && alu_result[0]) ||
                       (funct3[1:0] == 2'b10 && alu_result[1:0] != 2'b00);

   assign legal_op = op & ~illegal & ~misaligned;

   // ---------------- store lane placement ----------------
   always_comb begin
      st_data = data2;
      st_strb = 4'b1111;
      case (funct3[1:0])
         2'b00: begin
            st_data = {4{data2[7:0]}};
            st_strb = 4'b0001 << alu_result[1:0];
         end
         2'b01: begin
            st_data = {2{data2[15:0]}};
            st_strb = 4'b0011 << alu_result[1:0];
         end
         default: ;
      endcase
   end

   // ---------------- load extraction (latched offset/size) ----------------
   assign ld_shift = mem.mem_rdata >> {lat_off, 3'b000};
   assign ld_byte  = ld_shift[7:0];
   assign ld_half  = lat_off[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

   always_comb begin
      case (lat_f3)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = mem.mem_rdata;
      endcase
   end

   // ---------------- FSM next state / stall ----------------
   always_comb begin
      state_nxt   = state;
      stall       = 1'b0;
      done        = 1'b0;
      timeout_now = 1'b0;
      case (state)
         IDLE: begin
            if (legal_op) begin
               state_nxt = WAIT;
               stall     = 1'b1;
            end
         end
         WAIT: begin
            if (mem.mem_ready) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end else if (cnt == TO_LAST) begin
               timeout_now = 1'b1;
               state_nxt   = IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // ---------------- bus, MEM/WB register, fault ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem.mem_req        <= 1'b0;
         mem.mem_we         <= 1'b0;
         mem.mem_addr       <= '0;
         mem.mem_wdata      <= '0;
         mem.mem_wstrb      <= '0;
         mem_fault          <= 1'b0;
         cnt                <= '0;
         lat_off            <= '0;
         lat_f3             <= '0;
         lat_load           <= 1'b0;
         wb_alu_result      <= '0;
         wb_read_data       <= '0;
         wb_rd              <= '0;
         wb_regwrite_enable <= 1'b0;
         wb_mux3_select     <= 1'b0;
      end else begin
         mem_fault <= 1'b0;
         if (state == IDLE) begin
            if (!op) begin
               wb_alu_result      <= alu_result;
               wb_read_data       <= '0;
               wb_rd              <= rd;
               wb_regwrite_enable <= regwrite_enable;
               wb_mux3_select     <= mux3_select;
            end else begin
               // any memory op leaves a bubble here; a legal one writes back
               // from WAIT, an illegal one never writes back
               wb_alu_result      <= '0;
               wb_read_data       <= '0;
               wb_rd              <= '0;
               wb_regwrite_enable <= 1'b0;
               wb_mux3_select     <= 1'b0;
               if (legal_op) begin
                  mem.mem_req   <= 1'b1;
                  mem.mem_we    <= memory_write_enable;
                  mem.mem_addr  <= {alu_result[ADDR_WIDTH-1:2], 2'b00};
                  mem.mem_wdata <= memory_write_enable ? st_data : 32'd0;
                  mem.mem_wstrb <= memory_write_enable ? st_strb : 4'd0;
                  cnt           <= '0;
                  lat_off       <= alu_result[1:0];
                  lat_f3        <= funct3;
                  lat_load      <= memory_read_enable;
               end else begin
                  mem_fault <= 1'b1;
               end
            end
         end else begin
            if (done) begin
               // EX/MEM is frozen by stall, so the inputs still belong to this op
               wb_alu_result      <= alu_result;
               wb_read_data       <= lat_load ? ld_data : 32'd0;
               wb_rd              <= rd;
               wb_regwrite_enable <= regwrite_enable;
               wb_mux3_select     <= mux3_select;
               mem.mem_req        <= 1'b0;
               mem.mem_we         <= 1'b0;
               mem.mem_wstrb      <= '0;
            end else if (timeout_now) begin
               wb_alu_result      <= '0;
               wb_read_data       <= '0;
               wb_rd              <= '0;
               wb_regwrite_enable <= 1'b0;
               wb_mux3_select     <= 1'b0;
               mem.mem_req        <= 1'b0;
               mem.mem_we         <= 1'b0;
               mem.mem_wstrb      <= '0;
               mem_fault          <= 1'b1;
            end else begin
               cnt <= cnt + 8'd1;
            end
         end
      end
   end

endmodule
